// File: rtl/risc_pkg.sv
// Shared widths, access classes and opcode constants for the RISC pipeline.
// Used by the execution stage and the memory/write-back stage.
package risc_pkg;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int RW = 3;

   typedef enum logic [1:0] {
      ACC_ALU   = 2'd0,
      ACC_LOAD  = 2'd1,
      ACC_STORE = 2'd2,
      ACC_BAD   = 2'd3
   } acc_class_e;

   // Execution-stage opcode encoding
   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_SHL  = 4'h5;
   localparam logic [3:0] OP_SHR  = 4'h6;
   localparam logic [3:0] OP_LD   = 4'h8;
   localparam logic [3:0] OP_ST   = 4'h9;
   localparam logic [3:0] OP_NOP  = 4'hF;

endpackage

// File: rtl/risc_dmem.sv
// 2**AW x DW data memory: async clear, one write port, registered read port.
// Read data is valid one cycle after the address; no backpressure.
module risc_dmem
   import risc_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[addr] <= wdata;
      end
   end

   // Reads see the pre-edge contents, so a same-cycle store is not forwarded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/risc_memwb.sv
// Memory-access / write-back stage: classifies each access, drives the data memory and
// registers one write-back record per cycle (1-cycle latency, full rate, no backpressure).
module risc_memwb
   import risc_pkg::*;
#(
   parameter int CNTW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            dmenbl,
   input  logic            rdwr,
   input  logic [AW-1:0]   dmaddr,
   input  logic [DW-1:0]   dmdatain,
   input  logic [DW-1:0]   rslt,
   input  logic [RW-1:0]   dst,
   input  logic            reg_wr_vld,
   input  logic            load_op,
   output logic [DW-1:0]   wb_data,
   output logic [RW-1:0]   wb_dst,
   output logic            wb_en,
   output logic [CNTW-1:0] ld_cnt,
   output logic [CNTW-1:0] st_cnt,
   output logic            proto_err
);

   localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

   acc_class_e    acc;
   logic          mem_we;
   logic [DW-1:0] mem_rdata;
   logic [DW-1:0] alu_q;
   logic          ld_sel_q;

   always_comb begin
      acc = ACC_BAD;
      if (dmenbl && !rdwr) begin
         acc = ACC_STORE;
      end else if (dmenbl && rdwr && load_op) begin
         acc = ACC_LOAD;
      end else if (!dmenbl && !load_op) begin
         acc = ACC_ALU;
      end
   end

   assign mem_we = (acc == ACC_STORE);

   risc_dmem u_dmem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (mem_we),
      .addr  (dmaddr),
      .wdata (dmdatain),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_q     <= '0;
         ld_sel_q  <= 1'b0;
         wb_dst    <= '0;
         wb_en     <= 1'b0;
         ld_cnt    <= '0;
         st_cnt    <= '0;
         proto_err <= 1'b0;
      end else begin
         alu_q    <= rslt;
         ld_sel_q <= (acc == ACC_LOAD);
         wb_dst   <= dst;
         wb_en    <= ((acc == ACC_LOAD) || (acc == ACC_ALU)) && reg_wr_vld;
         if (acc == ACC_LOAD && ld_cnt != CNT_MAX) begin
            ld_cnt <= ld_cnt + 1'b1;
         end
         if (acc == ACC_STORE && st_cnt != CNT_MAX) begin
            st_cnt <= st_cnt + 1'b1;
         end
         if (acc == ACC_BAD) begin
            proto_err <= 1'b1;
         end
      end
   end

   // Both sources are registered, so this mux adds no input-to-output path
   assign wb_data = ld_sel_q ? mem_rdata : alu_q;

endmodule
